inject_sched: RTL and testbench
===============================

Name: inject_sched

Overview:
- Local-injection scheduler for one bufferless deflection router node.
- Queues flits from the local core; each cycle, picks a free incoming pipeline slot and hands one queued flit to the injector stage.
- Slot index convention: 0 east, 1 west, 2 north, 3 south.
- Raises a starvation flag toward the router when the node cannot inject for too long.

Parameters:
- ADDR_W, 6, width of flit destination address.
- DEPTH, 4, local queue depth in entries; power of two, at least 2.
- STARVE_MAX, 8, consecutive blocked cycles before starve_flag asserts; at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enq_valid  input  1  local core offers a flit.
- enq_addr  input  ADDR_W  destination address of the offered flit.
- enq_ready  output  1  queue can accept; equals (count != DEPTH).
- slot_busy  input  4  bit k=1: slot k is occupied by a through-flit this cycle.
- inj_valid  output  1  registered; an injection is issued this cycle.
- inj_sel  output  4  registered one-hot slot to inject into; 0 when inj_valid=0.
- inj_addr  output  ADDR_W  registered address of the injected flit; 0 when inj_valid=0.
- starve_flag  output  1  registered; node is starved.
- q_count  output  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst=1 at a clock edge): queue empty, rd/wr pointers 0, q_count=0, rr_ptr=0, starve counter 0, state=IDLE. Outputs inj_valid=0, inj_sel=0, inj_addr=0, starve_flag=0; enq_ready=1 on the next cycle. Reset mid-operation discards all queued flits.
- Push: occurs when enq_valid && enq_ready at the edge. Entry is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop/decision: when the queue is non-empty and slot_busy != 4'b1111 at edge t:
  - Select the first k with slot_busy[k]=0, scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Pop the head.
  - After edge t: inj_valid=1, inj_sel=1<<k, inj_addr=head. Outputs are valid for exactly one cycle (latency 1 from decision).
  - rr_ptr <= (k+1) mod 4.
- No bypass: a flit pushed at edge t can be injected at edge t+1 at the earliest, so visible on inj_* after t+1.
- Simultaneous push and pop: both take effect and q_count is unchanged. When full, enq_ready=0 even if a pop occurs the same cycle.
- Full: enq_ready=0, pushes ignored. Empty: no injection, inj_valid=0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each edge where the queue is non-empty and slot_busy=4'b1111.
  - Clears to 0 on any injection or when the queue is empty.
  - starve_flag is registered and equals (counter_next == STARVE_MAX). It therefore rises on the STARVE_MAX-th consecutive blocked edge and falls on the edge of the next injection.
- State machine (2-bit state register, transitions at the edge):
  - IDLE: queue empty. Goes to READY on push.
  - READY: non-empty, last cycle injected or just filled. Goes to BLOCKED if all slots busy; goes to IDLE if the pop empties the queue and there is no push.
  - BLOCKED: counter below STARVE_MAX. Goes to READY on injection; goes to STARVED when the counter reaches STARVE_MAX.
  - STARVED: starve_flag=1. Goes to READY (or IDLE if emptied) on injection.
- Address field is passed through unmodified; no arithmetic on addresses.

Optional Feature:
- Macro INJ_STATS_EN.
- When defined, adds two outputs:
  - inj_total (16-bit): increments on every injection.
  - blocked_total (16-bit): increments on every blocked edge (non-empty queue and all slots busy).
  - Both saturate at 16'hFFFF and are reset to 0 by rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, slot_busy=0 → inj_valid=0, inj_sel=0, starve_flag=0, q_count=0, enq_ready=1.
- Single inject: push addr 6'b101101 with slot_busy=4'b0001 → next edge inj_valid=1, inj_sel=4'b0010 (west), inj_addr=6'b101101; rr_ptr becomes 2; q_count returns to 0.
- Round-robin: push 3 flits; slot_busy=0 held → inj_sel sequence 4'b0001, 4'b0010, 4'b0100 on consecutive cycles.
- Full queue: push 4 flits with slot_busy=4'b1111 → q_count=4, enq_ready=0; fifth push ignored; release one slot → exactly one injection, then enq_ready=1.
- Starvation: 1 flit queued, slot_busy=4'b1111 for 8 edges → starve_flag=1 after the 8th edge; free slot 3 → inj_sel=4'b1000, starve_flag=0 on the same edge.
- Mid-operation reset: 3 flits queued, assert rst for one edge → q_count=0, inj_valid=0, starve_flag=0; no stale flits injected afterwards.

Source files
------------

// File: rtl/inject_sched.sv
// Local-injection scheduler for a bufferless deflection router: queues local flits, round-robin slot pick, starvation flag.
// Optional INJ_STATS_EN adds saturating inj_total / blocked_total counters.
module inject_sched #(
   parameter int ADDR_W     = 6,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enq_valid,
   input  logic [ADDR_W-1:0]       enq_addr,
   output logic                    enq_ready,
   input  logic [3:0]              slot_busy,
   output logic                    inj_valid,
   output logic [3:0]              inj_sel,
   output logic [ADDR_W-1:0]       inj_addr,
   output logic                    starve_flag,
   output logic [$clog2(DEPTH):0]  q_count
`ifdef INJ_STATS_EN
   ,
   output logic [15:0]             inj_total,
   output logic [15:0]             blocked_total
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, READY, BLOCKED, STARVED} state_t;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_next;
   logic [1:0]        rr_ptr, sel_k, idx;
   logic              found;
   logic [SW-1:0]     starve_cnt, starve_next;
   state_t            state;
   logic              push, pop, non_empty, all_busy, blocked;

   assign non_empty = (count != '0);
   assign all_busy  = &slot_busy;
   assign enq_ready = (count != CW'(DEPTH));
   assign push      = enq_valid && enq_ready;
   assign pop       = non_empty && !all_busy;
   assign blocked   = non_empty && all_busy;
   assign q_count   = count;

   // First free slot starting at rr_ptr, wrapping mod 4.
   always_comb begin
      sel_k = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!found && !slot_busy[idx]) begin
            sel_k = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
      starve_next = starve_cnt;
      if (pop || !non_empty)
         starve_next = '0;
      else if (starve_cnt != SW'(STARVE_MAX))
         starve_next = starve_cnt + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= enq_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rr_ptr      <= 2'd0;
         starve_cnt  <= '0;
         state       <= IDLE;
         inj_valid   <= 1'b0;
         inj_sel     <= 4'd0;
         inj_addr    <= '0;
         starve_flag <= 1'b0;
      end else begin
         count       <= count_next;
         starve_cnt  <= starve_next;
         starve_flag <= (starve_next == SW'(STARVE_MAX));
         inj_valid   <= pop;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PW'(1);
            rr_ptr   <= sel_k + 2'd1;
            inj_sel  <= 4'b0001 << sel_k;
            inj_addr <= mem[rd_ptr];
         end else begin
            inj_sel  <= 4'd0;
            inj_addr <= '0;
         end
         case (state)
            IDLE: if (push) state <= READY;
            default: begin
               if (count_next == '0)
                  state <= IDLE;
               else if (pop)
                  state <= READY;
               else if (starve_next == SW'(STARVE_MAX))
                  state <= STARVED;
               else
                  state <= BLOCKED;
            end
         endcase
      end
   end

`ifdef INJ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         inj_total     <= 16'd0;
         blocked_total <= 16'd0;
      end else begin
         if (pop && inj_total != 16'hFFFF)         inj_total     <= inj_total + 16'd1;
         if (blocked && blocked_total != 16'hFFFF) blocked_total <= blocked_total + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inject_sched.sv
// Bench for inject_sched: queue-based reference model checked every cycle, directed scenarios, then random traffic.
module tb_inject_sched;
   localparam int ADDR_W = 6;
   localparam int DEPTH = 4;
   localparam int STARVE_MAX = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enq_valid = 1'b0;
   logic [ADDR_W-1:0] enq_addr = '0;
   logic              enq_ready;
   logic [3:0]        slot_busy = 4'd0;
   logic              inj_valid;
   logic [3:0]        inj_sel;
   logic [ADDR_W-1:0] inj_addr;
   logic              starve_flag;
   logic [2:0]        q_count;

   int n_chk = 0;
   int n_fail = 0;

   inject_sched #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_addr(enq_addr),
      .enq_ready(enq_ready), .slot_busy(slot_busy), .inj_valid(inj_valid),
      .inj_sel(inj_sel), .inj_addr(inj_addr), .starve_flag(starve_flag),
      .q_count(q_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of addresses plus round-robin pointer and blocked-edge counter.
   logic [ADDR_W-1:0] m_q[$];
   int                m_rr = 0;
   int                m_scnt = 0;
   logic              m_valid = 1'b0;
   logic [3:0]        m_sel = 4'd0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic              m_flag = 1'b0;
   int                m_k, m_s;
   logic              m_push;

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_rr = 0; m_scnt = 0;
         m_valid = 1'b0; m_sel = 4'd0; m_addr = '0; m_flag = 1'b0;
      end else begin
         m_push = enq_valid && (m_q.size() != DEPTH);
         if (m_q.size() > 0 && slot_busy != 4'hF) begin
            m_k = -1;
            for (int j = 0; j < 4; j++) begin
               m_s = (m_rr + j) % 4;
               if (m_k < 0 && !slot_busy[m_s]) m_k = m_s;
            end
            m_valid = 1'b1;
            m_sel = 4'(1 << m_k);
            m_addr = m_q.pop_front();
            m_rr = (m_k + 1) % 4;
            m_scnt = 0;
         end else begin
            m_valid = 1'b0; m_sel = 4'd0; m_addr = '0;
            if (m_q.size() > 0) m_scnt = (m_scnt < STARVE_MAX) ? m_scnt + 1 : STARVE_MAX;
            else m_scnt = 0;
         end
         m_flag = (m_scnt == STARVE_MAX);
         if (m_push) m_q.push_back(enq_addr);
      end
   end

   always @(posedge clk) begin
      #2;
      check("inj_valid", 32'(inj_valid), 32'(m_valid));
      check("inj_sel", 32'(inj_sel), 32'(m_sel));
      check("inj_addr", 32'(inj_addr), 32'(m_addr));
      check("starve_flag", 32'(starve_flag), 32'(m_flag));
      check("q_count", 32'(q_count), 32'(m_q.size()));
      check("enq_ready", 32'(enq_ready), 32'(m_q.size() != DEPTH));
   end

   task automatic drive(input logic r, input logic v, input logic [ADDR_W-1:0] a, input logic [3:0] b);
      @(negedge clk);
      rst = r; enq_valid = v; enq_addr = a; slot_busy = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   int mode;

   initial begin
      // Reset then idle
      drive(1, 0, 0, 0); tick(); tick();
      check("rst_inj_valid", 32'(inj_valid), 32'd0);
      check("rst_inj_sel", 32'(inj_sel), 32'd0);
      check("rst_starve", 32'(starve_flag), 32'd0);
      check("rst_q_count", 32'(q_count), 32'd0);
      check("rst_enq_ready", 32'(enq_ready), 32'd1);

      // Single inject into west with east busy
      drive(0, 1, 6'b101101, 4'b0001); tick();
      check("single_no_bypass", 32'(inj_valid), 32'd0);
      drive(0, 0, 0, 4'b0001); tick();
      check("single_valid", 32'(inj_valid), 32'd1);
      check("single_sel", 32'(inj_sel), 32'b0010);
      check("single_addr", 32'(inj_addr), 32'b101101);
      check("single_q_count", 32'(q_count), 32'd0);
      drive(0, 0, 0, 0); tick();
      check("single_one_cycle", 32'(inj_valid), 32'd0);

      // Round-robin from rr_ptr 0
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 6'h11, 0); tick();
      drive(0, 1, 6'h22, 0); tick();
      check("rr_sel0", 32'(inj_sel), 32'b0001);
      check("rr_addr0", 32'(inj_addr), 32'h11);
      drive(0, 1, 6'h33, 0); tick();
      check("rr_sel1", 32'(inj_sel), 32'b0010);
      drive(0, 0, 0, 0); tick();
      check("rr_sel2", 32'(inj_sel), 32'b0100);
      check("rr_addr2", 32'(inj_addr), 32'h33);
      drive(0, 0, 0, 0); tick();
      check("rr_drained", 32'(inj_valid), 32'd0);

      // Full queue; rr_ptr is now 3 so freeing slot 0 picks east
      drive(0, 1, 6'h01, 4'hF); tick();
      drive(0, 1, 6'h02, 4'hF); tick();
      drive(0, 1, 6'h03, 4'hF); tick();
      drive(0, 1, 6'h04, 4'hF); tick();
      check("full_q_count", 32'(q_count), 32'd4);
      check("full_enq_ready", 32'(enq_ready), 32'd0);
      drive(0, 1, 6'h3F, 4'hF); tick();
      check("full_ignored", 32'(q_count), 32'd4);
      drive(0, 0, 0, 4'b1110); tick();
      check("full_release_valid", 32'(inj_valid), 32'd1);
      check("full_release_sel", 32'(inj_sel), 32'b0001);
      check("full_release_addr", 32'(inj_addr), 32'h01);
      check("full_release_ready", 32'(enq_ready), 32'd1);
      drive(0, 0, 0, 4'hF); tick();
      check("full_exactly_one", 32'(inj_valid), 32'd0);
      check("full_q_after", 32'(q_count), 32'd3);

      // Starvation: one flit, all slots busy
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 6'h2A, 4'hF); tick();
      for (int i = 1; i <= STARVE_MAX; i++) begin
         drive(0, 0, 0, 4'hF); tick();
         if (i == STARVE_MAX - 1) check("starve_not_yet", 32'(starve_flag), 32'd0);
      end
      check("starve_set", 32'(starve_flag), 32'd1);
      drive(0, 0, 0, 4'b0111); tick();
      check("starve_sel", 32'(inj_sel), 32'b1000);
      check("starve_addr", 32'(inj_addr), 32'h2A);
      check("starve_clear", 32'(starve_flag), 32'd0);

      // Mid-operation reset discards queued flits
      drive(0, 1, 6'h05, 4'hF); tick();
      drive(0, 1, 6'h06, 4'hF); tick();
      drive(0, 1, 6'h07, 4'hF); tick();
      check("midrst_q3", 32'(q_count), 32'd3);
      drive(1, 0, 0, 0); tick();
      check("midrst_q0", 32'(q_count), 32'd0);
      check("midrst_valid", 32'(inj_valid), 32'd0);
      check("midrst_starve", 32'(starve_flag), 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0); tick();
         check("midrst_no_stale", 32'(inj_valid), 32'd0);
      end

      // Random traffic in phases: free-flowing, mixed, jammed
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 40 == 0) mode = int'($urandom_range(0, 2));
         drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) != 0),
               ADDR_W'($urandom),
               (mode == 2) ? (($urandom_range(0, 15) == 0) ? 4'(~(4'b1 << $urandom_range(0, 3))) : 4'hF) :
               (mode == 1) ? 4'($urandom) : 4'($urandom & $urandom));
      end
      drive(0, 0, 0, 0); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
